// File: rtl/wormhole_grant_ctrl_npu.sv
// wormhole_grant_ctrl_npu
//
// Credit-aware wormhole controller for one router output port. It arbitrates
// round-robin among N input ports for the right to start a packet. It holds
// the grant on the winning input from its head flit through its tail flit. It
// never lets a flit cross unless the downstream buffer has a free credit.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_i          per-input: valid flit waiting for this output
//   is_head_i      per-input: presented flit is a head flit
//   is_tail_i      per-input: presented flit is a tail flit
//   credit_inc_i   downstream returned one credit this cycle
//   grant_o        one-hot crossbar select / per-input pop strobe
//   grant_valid_o  a flit crosses this cycle (OR of grant_o)
//   locked_o       a multi-flit packet currently owns the output
//   owner_o        index of the owning input, valid while locked_o
//   credit_cnt_o   current downstream credit count

module wormhole_grant_ctrl_npu #(
  parameter int unsigned N          = 4,
  parameter int unsigned CREDIT_MAX = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N-1:0]                    req_i,
  input  logic [N-1:0]                    is_head_i,
  input  logic [N-1:0]                    is_tail_i,
  input  logic                            credit_inc_i,
  output logic [N-1:0]                    grant_o,
  output logic                            grant_valid_o,
  output logic                            locked_o,
  output logic [$clog2(N)-1:0]            owner_o,
  output logic [$clog2(CREDIT_MAX+1)-1:0] credit_cnt_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(CREDIT_MAX + 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   credit_q, credit_d;

  logic              credit_ok;
  logic [N-1:0]      eligible;
  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [31:0]       scan_idx;

  assign credit_ok = (credit_q != '0);
  assign eligible  = req_i & is_head_i;

  // Round-robin scan starting at ptr_q with wraparound; first eligible wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!win_found && eligible[scan_idx[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  // Grant and next-state logic.
  always_comb begin
    grant_o = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    // Grant is forced low while reset is asserted, even though the
    // registers already hold their reset values.
    if (rst_ni && credit_ok) begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_o[win_idx] = 1'b1;
            ptr_d = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + 1'b1;
            if (!is_tail_i[win_idx]) begin
              owner_d = win_idx;
              state_d = StLocked;
            end
          end
        end
        StLocked: begin
          // Heads from the owner are treated as body flits here.
          if (req_i[owner_q]) begin
            grant_o[owner_q] = 1'b1;
            if (is_tail_i[owner_q]) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign grant_valid_o = |grant_o;

  // Credit counter: a transfer and a returned credit in one cycle cancel.
  always_comb begin
    credit_d = credit_q;
    if (grant_valid_o && !credit_inc_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!grant_valid_o && credit_inc_i) begin
      if (credit_q != CntW'(CREDIT_MAX)) credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= CntW'(CREDIT_MAX);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign locked_o     = (state_q == StLocked);
  assign owner_o      = owner_q;
  assign credit_cnt_o = credit_q;

endmodule

// File: tb/tb_wormhole_grant_ctrl_npu.sv
// Directed bench for wormhole_grant_ctrl_npu with N=4, CREDIT_MAX=2.
// Inputs change 1 time unit after a rising edge; combinational and
// registered outputs are sampled 1 unit later, well away from the edges.

module tb_wormhole_grant_ctrl_npu;

  localparam int unsigned N          = 4;
  localparam int unsigned CREDIT_MAX = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, head, tail;
  logic       inc;
  logic [3:0] grant;
  logic       grant_valid;
  logic       locked;
  logic [1:0] owner;
  logic [1:0] credit_cnt;

  int checks = 0;
  int errors = 0;

  wormhole_grant_ctrl_npu #(
    .N          (N),
    .CREDIT_MAX (CREDIT_MAX)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .is_head_i     (head),
    .is_tail_i     (tail),
    .credit_inc_i  (inc),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .locked_o      (locked),
    .owner_o       (owner),
    .credit_cnt_o  (credit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] h, input logic [3:0] t,
                       input logic ci);
    req  = r;
    head = h;
    tail = t;
    inc  = ci;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks grant, then state registers (as left by the previous edge).
  task automatic chk_cyc(input string tag, input logic [3:0] g, input logic lk,
                         input logic [1:0] cc);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".gvalid"}, 32'(grant_valid), 32'(g != 4'b0));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".credit"}, 32'(credit_cnt), 32'(cc));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset held with every input offering a single-flit packet.
    tick();
    tick();
    drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
    chk_cyc("reset", 4'b0000, 1'b0, 2'd2);

    // Release between edges; input 0 wins first.
    rst_n = 1'b1;
    #1;
    chk_cyc("rr0", 4'b0001, 1'b0, 2'd2);
    tick();
    chk_cyc("rr1", 4'b0010, 1'b0, 2'd2);
    tick();
    chk_cyc("rr2", 4'b0100, 1'b0, 2'd2);
    tick();
    chk_cyc("rr3", 4'b1000, 1'b0, 2'd2);
    tick();
    chk_cyc("rr4", 4'b0001, 1'b0, 2'd2);
    tick();

    // ptr=1: send one packet from input 1 so that ptr moves to 2.
    drive(4'b0010, 4'b0010, 4'b0010, 1'b1);
    chk_cyc("pre_worm", 4'b0010, 1'b0, 2'd2);
    tick();

    // Input 2 head/body/tail while input 1 keeps a head request.
    drive(4'b0110, 4'b0110, 4'b0010, 1'b1);
    chk_cyc("worm_head", 4'b0100, 1'b0, 2'd2);
    tick();
    drive(4'b0110, 4'b0110, 4'b0010, 1'b1); // head on owner ignored in LOCKED
    chk_cyc("worm_body", 4'b0100, 1'b1, 2'd2);
    chk("worm_owner_b", 32'(owner), 32'd2);
    tick();
    drive(4'b0110, 4'b0010, 4'b0110, 1'b1);
    chk_cyc("worm_tail", 4'b0100, 1'b1, 2'd2);
    chk("worm_owner_t", 32'(owner), 32'd2);
    tick();
    drive(4'b0010, 4'b0010, 4'b0010, 1'b1);
    chk_cyc("worm_next", 4'b0010, 1'b0, 2'd2);
    tick();

    // ptr=2. Drain to 1 credit, then transfer + credit_inc together.
    drive(4'b0100, 4'b0100, 4'b0100, 1'b0);
    chk_cyc("sim_a", 4'b0100, 1'b0, 2'd2);
    tick();
    drive(4'b1000, 4'b1000, 4'b1000, 1'b1);
    chk_cyc("sim_b", 4'b1000, 1'b0, 2'd1);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk_cyc("sim_c", 4'b0000, 1'b0, 2'd1);
    tick();
    chk_cyc("sim_d", 4'b0000, 1'b0, 2'd2);
    tick();
    chk_cyc("sim_sat", 4'b0000, 1'b0, 2'd2);

    // ptr=0. Input 0 sends a 4-flit packet with no returned credits.
    drive(4'b0011, 4'b0011, 4'b0000, 1'b0);
    chk_cyc("stall_h", 4'b0001, 1'b0, 2'd2);
    tick();
    drive(4'b0011, 4'b0010, 4'b0000, 1'b0);
    chk_cyc("stall_b1", 4'b0001, 1'b1, 2'd1);
    chk("stall_owner", 32'(owner), 32'd0);
    tick();
    drive(4'b0011, 4'b0010, 4'b0000, 1'b1); // credit arrives, not yet usable
    chk_cyc("stall_b2", 4'b0000, 1'b1, 2'd0);
    tick();
    drive(4'b0011, 4'b0010, 4'b0000, 1'b0);
    chk_cyc("stall_b2go", 4'b0001, 1'b1, 2'd1);
    tick();
    drive(4'b0011, 4'b0010, 4'b0001, 1'b1);
    chk_cyc("stall_t", 4'b0000, 1'b1, 2'd0);
    tick();
    drive(4'b0011, 4'b0010, 4'b0001, 1'b0);
    chk_cyc("stall_tgo", 4'b0001, 1'b1, 2'd1);
    tick();

    // Idle, credit 0, ptr=1. Request without head must be ignored.
    drive(4'b0010, 4'b0000, 4'b0000, 1'b1);
    chk_cyc("nohead0", 4'b0000, 1'b0, 2'd0);
    tick();
    drive(4'b0010, 4'b0000, 4'b0000, 1'b0);
    chk_cyc("nohead1", 4'b0000, 1'b0, 2'd1);
    tick();

    // ptr=1: input 3 head wins and locks the output.
    drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
    chk_cyc("mid_head", 4'b1000, 1'b0, 2'd1);
    tick();
    drive(4'b1000, 4'b0000, 4'b0000, 1'b0);
    chk_cyc("mid_lock", 4'b1000, 1'b1, 2'd1);
    chk("mid_owner", 32'(owner), 32'd3);

    // Asynchronous reset mid-packet, between edges.
    rst_n = 1'b0;
    #1;
    chk_cyc("mid_rst", 4'b0000, 1'b0, 2'd2);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_cyc("mid_body", 4'b0000, 1'b0, 2'd2);
    tick();

    // ptr back at 0: inputs 1 and 3 both offer heads, 1 is first.
    drive(4'b1010, 4'b1010, 4'b1010, 1'b0);
    chk_cyc("post_rst", 4'b0010, 1'b0, 2'd2);
    tick();
    chk_cyc("post_rst2", 4'b1000, 1'b0, 2'd1);
    tick();
    chk_cyc("post_empty", 4'b0000, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
